// File: rtl/urp_pcie_demux.sv
`timescale 1ns/1ps
// urp_pcie_demux: steers one valid/ready stream onto N_SLAVE outputs using a
// destination index carried in the beat; every output has its own 2-entry FIFO.
module urp_pcie_demux #(
    parameter int  N_SLAVE   = 2,
    parameter int  DATA_SIZE = 224,
    parameter int  SEL_LSB   = 0,
    localparam int SEL_W     = $clog2(N_SLAVE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    input  logic [DATA_SIZE-1:0] src_data_i,
    output logic [N_SLAVE-1:0]   dst_valid_o,
    input  logic [N_SLAVE-1:0]   dst_ready_i,
    output logic [DATA_SIZE-1:0] dst_data_o [N_SLAVE],
    output logic [15:0]          drop_cnt_o
);
    logic                 in_vld_r;
    logic [DATA_SIZE-1:0] in_data_r;
    logic [SEL_W-1:0]     in_idx_r;
    logic [DATA_SIZE-1:0] mem_r [N_SLAVE][2];
    logic [N_SLAVE-1:0]   head_r;
    logic [1:0]           cnt_r [N_SLAVE];
    logic [15:0]          drop_cnt_r;

    logic [N_SLAVE-1:0]   full_s;
    logic [N_SLAVE-1:0]   pop_s;
    logic [N_SLAVE-1:0]   sel_s;
    logic [N_SLAVE-1:0]   push_s;
    logic                 in_range_s;
    logic                 drop_s;
    logic                 dispatch_s;
    logic                 accept_s;

    // Destination decode, FIFO status and dispatch decision for the held beat
    always_comb begin
        in_range_s = (32'(in_idx_r) < 32'(N_SLAVE));
        for (int i = 0; i < N_SLAVE; i++) begin
            full_s[i] = (cnt_r[i] == 2'd2);
            pop_s[i]  = (cnt_r[i] != 2'd0) && dst_ready_i[i];
            sel_s[i]  = in_vld_r && (32'(in_idx_r) == 32'(i));
            // a full target still accepts when its head leaves this cycle
            push_s[i] = sel_s[i] && (!full_s[i] || pop_s[i]);
        end
        drop_s     = in_vld_r && !in_range_s;
        dispatch_s = (|push_s) || drop_s;
    end

    assign src_ready_o = !in_vld_r || dispatch_s;
    assign accept_s    = src_valid_i && src_ready_o;

    // Input register: reload on accept, empty on dispatch without a new beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vld_r  <= 1'b0;
            in_data_r <= {DATA_SIZE{1'b0}};
            in_idx_r  <= {SEL_W{1'b0}};
        end else if (accept_s) begin
            in_vld_r  <= 1'b1;
            in_data_r <= src_data_i;
            in_idx_r  <= src_data_i[SEL_LSB +: SEL_W];
        end else if (dispatch_s) begin
            in_vld_r  <= 1'b0;
        end
    end

    // Per-output FIFO storage, head pointer and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLAVE; i++) begin
                mem_r[i][0] <= {DATA_SIZE{1'b0}};
                mem_r[i][1] <= {DATA_SIZE{1'b0}};
                head_r[i]   <= 1'b0;
                cnt_r[i]    <= 2'd0;
            end
        end else begin
            for (int i = 0; i < N_SLAVE; i++) begin
                // tail slot is head+count mod 2; at count 2 it is the slot being popped
                if (push_s[i]) begin
                    mem_r[i][head_r[i] ^ cnt_r[i][0]] <= in_data_r;
                end
                if (pop_s[i]) begin
                    head_r[i] <= ~head_r[i];
                end
                if (push_s[i] && !pop_s[i]) begin
                    cnt_r[i] <= cnt_r[i] + 2'd1;
                end else if (pop_s[i] && !push_s[i]) begin
                    cnt_r[i] <= cnt_r[i] - 2'd1;
                end
            end
        end
    end

    // Saturating count of beats discarded for an out-of-range index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    // Output views of the FIFO heads
    always_comb begin
        for (int i = 0; i < N_SLAVE; i++) begin
            dst_valid_o[i] = (cnt_r[i] != 2'd0);
            dst_data_o[i]  = mem_r[i][head_r[i]];
        end
    end

    assign drop_cnt_o = drop_cnt_r;

endmodule

// File: tb/tb_urp_pcie_demux.sv
`timescale 1ns/1ps
// Directed bench for urp_pcie_demux: a 2-output instance checked against
// per-destination scoreboards, and a 3-output instance for the drop counter.
module tb_urp_pcie_demux;
    localparam int DW = 224;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          src_valid, src_ready;
    logic [DW-1:0] src_data;
    logic [1:0]    dst_valid, dst_ready;
    logic [DW-1:0] dst_data [2];
    logic [15:0]   drop_cnt;

    logic          src_valid3, src_ready3;
    logic [DW-1:0] src_data3;
    logic [2:0]    dst_valid3, dst_ready3;
    logic [DW-1:0] dst_data3 [3];
    logic [15:0]   drop_cnt3;

    urp_pcie_demux #(.N_SLAVE(2), .DATA_SIZE(DW), .SEL_LSB(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid_i(src_valid), .src_ready_o(src_ready), .src_data_i(src_data),
        .dst_valid_o(dst_valid), .dst_ready_i(dst_ready), .dst_data_o(dst_data),
        .drop_cnt_o(drop_cnt)
    );

    urp_pcie_demux #(.N_SLAVE(3), .DATA_SIZE(DW), .SEL_LSB(0)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .src_valid_i(src_valid3), .src_ready_o(src_ready3), .src_data_i(src_data3),
        .dst_valid_o(dst_valid3), .dst_ready_i(dst_ready3), .dst_data_o(dst_data3),
        .drop_cnt_o(drop_cnt3)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    int            pop1_cnt = 0;
    int            acc3     = 0;
    logic          any_valid3 = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] beat(input logic [31:0] tag, input logic [7:0] low);
        return {tag, 184'd0, low};
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake
    always @(negedge clk) begin
        if (src_valid && src_ready) begin
            if (src_data[0]) exp_q1.push_back(src_data);
            else             exp_q0.push_back(src_data);
        end
        if (dst_valid[0] && dst_ready[0]) begin
            check("dst0_expected_beat", DW'(exp_q0.size() != 0), DW'(1));
            if (exp_q0.size() != 0) check("dst0_data", dst_data[0], exp_q0.pop_front());
        end
        if (dst_valid[1] && dst_ready[1]) begin
            pop1_cnt++;
            check("dst1_expected_beat", DW'(exp_q1.size() != 0), DW'(1));
            if (exp_q1.size() != 0) check("dst1_data", dst_data[1], exp_q1.pop_front());
        end
        if (src_valid3 && src_ready3) acc3++;
        if (|dst_valid3) any_valid3 = 1'b1;
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat; returns in the cycle after acceptance, #1 past the edge
    task automatic send(input logic [DW-1:0] d, output int waited);
        src_valid = 1'b1;
        src_data  = d;
        waited    = 0;
        @(negedge clk);
        while (!src_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!src_ready) check("send_timeout", DW'(src_ready), DW'(1));
        @(posedge clk);
        #1;
        src_valid = 1'b0;
    endtask

    initial begin
        int w;
        int p0;
        rst_n      = 1'b0;
        src_valid  = 1'b0;
        src_data   = {DW{1'b0}};
        dst_ready  = 2'b11;
        src_valid3 = 1'b0;
        src_data3  = {DW{1'b0}};
        dst_ready3 = 3'b111;

        #12;
        check("rst_src_ready", DW'(src_ready), DW'(1));
        check("rst_dst_valid", DW'(dst_valid), DW'(0));
        check("rst_drop_cnt", DW'(drop_cnt), DW'(0));
        check("rst_dst_data0", dst_data[0], {DW{1'b0}});
        sync();
        rst_n = 1'b1;
        sync();

        // basic routing and 2-cycle latency
        send(beat(32'hA0A0_0000, 8'hA0), w);
        check("basic_a_wait", DW'(w), DW'(0));
        @(negedge clk);
        check("basic_a_t1_valid", DW'(dst_valid[0]), DW'(0));
        @(negedge clk);
        check("basic_a_t2_valid", DW'(dst_valid[0]), DW'(1));
        check("basic_a_t2_data", dst_data[0], beat(32'hA0A0_0000, 8'hA0));
        sync();
        send(beat(32'hB1B1_0000, 8'hB1), w);
        @(negedge clk);
        check("basic_b_t1_valid", DW'(dst_valid[1]), DW'(0));
        @(negedge clk);
        check("basic_b_t2_valid", DW'(dst_valid[1]), DW'(1));
        check("basic_b_t2_data", dst_data[1], beat(32'hB1B1_0000, 8'hB1));
        sync();

        // backpressure and ordering on destination 0
        dst_ready = 2'b10;
        for (int v = 1; v <= 3; v++) send(beat(32'(v), 8'h00), w);
        @(negedge clk);
        check("bp_stall", DW'(src_ready), DW'(0));
        check("bp_head_valid", DW'(dst_valid[0]), DW'(1));
        check("bp_head_data", dst_data[0], beat(32'd1, 8'h00));
        @(negedge clk);
        check("bp_stall_held", DW'(src_ready), DW'(0));
        sync();
        dst_ready = 2'b11;
        send(beat(32'd4, 8'h00), w);
        check("bp_release_wait", DW'(w), DW'(0));
        repeat (6) @(negedge clk);
        check("bp_ready_after", DW'(src_ready), DW'(1));
        check("bp_drained", DW'(exp_q0.size()), DW'(0));
        sync();

        // independence: idx 1 flows while FIFO[0] is full
        dst_ready = 2'b10;
        send(beat(32'h10, 8'h00), w);
        send(beat(32'h11, 8'h00), w);
        for (int k = 0; k < 4; k++) begin
            send(beat(32'h20 + 32'(k), 8'h01), w);
            check($sformatf("indep_flow_%0d", k), DW'(w), DW'(0));
        end
        send(beat(32'h12, 8'h00), w);
        check("indep_idx0_accept", DW'(w), DW'(0));
        src_valid = 1'b1;
        src_data  = beat(32'h30, 8'h01);
        repeat (2) begin
            @(negedge clk);
            check("indep_blocked", DW'(src_ready), DW'(0));
        end
        sync();
        dst_ready = 2'b11;
        send(beat(32'h30, 8'h01), w);
        repeat (6) @(negedge clk);
        check("indep_q0_empty", DW'(exp_q0.size()), DW'(0));
        check("indep_q1_empty", DW'(exp_q1.size()), DW'(0));
        sync();

        // full-rate push/pop with FIFO[1] full and input register loaded
        dst_ready = 2'b01;
        for (int k = 0; k < 3; k++) send(beat(32'h40 + 32'(k), 8'h01), w);
        dst_ready = 2'b11;
        p0 = pop1_cnt;
        for (int k = 0; k < 10; k++) begin
            send(beat(32'h50 + 32'(k), 8'h01), w);
            check($sformatf("fr_ready_%0d", k), DW'(w), DW'(0));
        end
        check("fr_one_per_cycle", DW'(pop1_cnt - p0), DW'(10));
        repeat (6) @(negedge clk);
        check("fr_q1_empty", DW'(exp_q1.size()), DW'(0));
        sync();

        // reset with two beats buffered
        dst_ready = 2'b00;
        send(beat(32'h60, 8'h00), w);
        send(beat(32'h61, 8'h00), w);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", DW'(dst_valid), DW'(0));
        check("mid_rst_ready", DW'(src_ready), DW'(1));
        check("mid_rst_drop", DW'(drop_cnt), DW'(0));
        check("mid_rst_data0", dst_data[0], {DW{1'b0}});
        exp_q0.delete();
        exp_q1.delete();
        sync();
        rst_n = 1'b1;
        dst_ready = 2'b11;
        repeat (5) @(negedge clk);
        check("post_rst_idle", DW'(dst_valid), DW'(0));
        sync();

        // drop counter on the 3-output instance
        check("drop_init", DW'(drop_cnt3), DW'(0));
        any_valid3 = 1'b0;
        acc3       = 0;
        src_valid3 = 1'b1;
        src_data3  = beat(32'h70, 8'h03);
        repeat (5) @(posedge clk);
        #1;
        src_valid3 = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_accepted5", DW'(acc3), DW'(5));
        check("drop_cnt5", DW'(drop_cnt3), DW'(5));
        check("drop_no_valid", DW'(any_valid3), DW'(0));
        sync();
        src_valid3 = 1'b1;
        src_data3  = beat(32'h71, 8'h02);
        sync();
        src_valid3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("n3_route_valid", DW'(dst_valid3), DW'(3'b100));
        check("n3_route_data", dst_data3[2], beat(32'h71, 8'h02));
        sync();

        // saturation: 65535 drops total, then one more
        any_valid3 = 1'b0;
        acc3       = 0;
        src_valid3 = 1'b1;
        src_data3  = beat(32'h72, 8'h03);
        repeat (65530) @(posedge clk);
        #1;
        src_valid3 = 1'b0;
        repeat (3) @(negedge clk);
        check("sat_accepted", DW'(acc3), DW'(65530));
        check("sat_reach_ffff", DW'(drop_cnt3), DW'(16'hFFFF));
        sync();
        src_valid3 = 1'b1;
        sync();
        src_valid3 = 1'b0;
        repeat (3) @(negedge clk);
        check("sat_hold_ffff", DW'(drop_cnt3), DW'(16'hFFFF));
        check("sat_no_valid", DW'(any_valid3), DW'(0));

        check("final_q0_empty", DW'(exp_q0.size()), DW'(0));
        check("final_q1_empty", DW'(exp_q1.size()), DW'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
